// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the uart_tx scheduler: FSM state codes,
// frame geometry and the index-width helper used by the arbiter and the top.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // start, 8 data bits, parity, stop
    localparam int UART_FRAME_BITS = 11;
    localparam int DEFAULT_NUM_REQ = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: rotate the request vector by the pointer,
// pick the lowest set bit, then rotate the index back into requester space.
module uart_tx_sched_rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IW-1:0]      win_idx,
    output logic               any_valid
);

    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      pe;
    logic [IW:0]        sum;

    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        pe  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) pe = IW'(k);
        end
        sum = {1'b0, ptr} + {1'b0, pe};
        if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
    end

    assign any_valid = |req;
    assign win_idx   = sum[IW-1:0];
    assign win_oh    = any_valid ? (NUM_REQ'(1) << win_idx) : '0;

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx serializer among NUM_REQ byte streams: round-robin pick,
// one-cycle start pulse, then follow ready_tx through busy and back to idle.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ      = DEFAULT_NUM_REQ,
    parameter bit LOCK_PKT     = 1'b1,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [1:0]           dbg_state
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
    logic               lock, lock_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [7:0]         tx_data_nxt;
    logic               tx_valid_nxt;
    logic [NUM_REQ-1:0] req_ready_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic               busy_nxt;
    logic               err_nxt;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] win_oh;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      ptr_inc;
    logic               win_any;
    logic [7:0]         win_data;
    logic               win_last;
    logic               timeout_hit;

    // While a packet is locked the held grant doubles as the eligibility mask.
    assign elig = req_valid & {NUM_REQ{tx_ready}} & (lock ? grant : {NUM_REQ{1'b1}});

    uart_tx_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req       (elig),
        .ptr       (rr_ptr),
        .win_oh    (win_oh),
        .win_idx   (win_idx),
        .any_valid (win_any)
    );

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_oh[k]) begin
                win_data = req_data[8*k +: 8];
                win_last = req_last[k];
            end
        end
    end

    assign ptr_inc     = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
    assign timeout_hit = (state == S_WAIT_BUSY) && tx_ready && (cnt == CNT_LAST);
    assign dbg_state   = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (win_any) state_nxt = S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!tx_ready)        state_nxt = S_WAIT_DONE;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_WAIT_DONE: if (tx_ready) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_data_nxt   = tx_data;
        tx_valid_nxt  = 1'b0;
        req_ready_nxt = '0;
        grant_nxt     = grant;
        lock_nxt      = lock;
        rr_ptr_nxt    = rr_ptr;
        cnt_nxt       = cnt;
        err_nxt       = 1'b0;
        busy_nxt      = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: begin
                if (win_any) begin
                    tx_data_nxt   = win_data;
                    tx_valid_nxt  = 1'b1;
                    req_ready_nxt = win_oh;
                    grant_nxt     = win_oh;
                    lock_nxt      = LOCK_PKT & ~win_last;
                    // The pointer only moves once the owner's packet is complete.
                    if (!lock_nxt) rr_ptr_nxt = ptr_inc;
                end
            end
            S_ISSUE: cnt_nxt = '0;
            S_WAIT_BUSY: begin
                if (tx_ready) begin
                    if (timeout_hit) begin
                        err_nxt   = 1'b1;
                        grant_nxt = '0;
                        lock_nxt  = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_WAIT_DONE: if (tx_ready && !lock) grant_nxt = '0;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr      <= '0;
            lock        <= 1'b0;
            cnt         <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            req_ready   <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            rr_ptr      <= rr_ptr_nxt;
            lock        <= lock_nxt;
            cnt         <= cnt_nxt;
            tx_data     <= tx_data_nxt;
            tx_valid    <= tx_valid_nxt;
            req_ready   <= req_ready_nxt;
            grant       <= grant_nxt;
            busy        <= busy_nxt;
            err_timeout <= err_nxt;
        end
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one uart_tx serializer between NUM_REQ byte-stream requesters. It arbitrates among pending bytes and issues each byte to uart_tx as a one-cycle tx_valid pulse. It then tracks the serializer's ready_tx through busy and idle, and optionally holds the grant for a whole packet until the requester marks its last byte. It sits between the host-side message sources and the uart_tx instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LOCK_PKT, 1, 1 = grant held until req_last byte accepted; 0 = re-arbitrate every byte
BUSY_TIMEOUT, 4, max cycles in S_WAIT_BUSY waiting for tx_ready to fall before error

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous reset, active low
req_valid  in  NUM_REQ  per-requester byte pending
req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]
req_last  in  NUM_REQ  byte is last of packet
req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
tx_data  out  8  byte to uart_tx data_send
tx_valid  out  1  one-cycle start pulse to uart_tx tx_valid
tx_ready  in  1  from uart_tx ready_tx
grant  out  NUM_REQ  one-hot current owner, 0 when none
busy  out  1  high in any state other than S_IDLE
err_timeout  out  1  one-cycle pulse on busy-wait timeout

Behaviour:
- Clock is i_clk. Reset is i_rst_n, asynchronous, active-low.
- Reset values: tx_valid=0, tx_data=0, req_ready=0, grant=0, busy=0, err_timeout=0. Internal: rr_ptr=0, lock=0, state=S_IDLE.
- All outputs are registered.
- States: S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE.
- S_IDLE, eligibility: requester i is eligible if req_valid[i]=1 and tx_ready=1.
  - If lock=1, only the locked owner is eligible; other requesters are ignored even while it is idle.
- S_IDLE, winner selection: the winner is the first eligible index searching upward from rr_ptr, wrapping modulo NUM_REQ.
- S_IDLE, winner actions on the next edge:
  - tx_data <= req_data[w], tx_valid <= 1, req_ready[w] <= 1, grant <= onehot(w).
  - lock <= LOCK_PKT & ~req_last[w].
  - go to S_ISSUE.
- Latency: tx_valid rises 1 cycle after the IDLE cycle in which the request was seen.
- S_ISSUE lasts exactly 1 cycle. On exit, tx_valid <= 0 and req_ready <= 0, then go to S_WAIT_BUSY with the timeout counter cleared.
- S_WAIT_BUSY:
  - tx_ready=0 → S_WAIT_DONE.
  - Otherwise the counter increments. When it reaches BUSY_TIMEOUT-1 with tx_ready still 1: pulse err_timeout, clear grant and lock, go to S_IDLE.
- S_WAIT_DONE:
  - Wait for tx_ready=1, then go to S_IDLE.
  - grant stays asserted only if lock=1; otherwise it is cleared on exit.
- rr_ptr update: rr_ptr <= (w+1) mod NUM_REQ when the packet ends (lock becomes 0). It is unchanged while locked.
- Requester contract:
  - Hold req_valid, req_data and req_last stable until req_ready is seen.
  - Deassertion before acceptance is legal; nothing is sent.
- Simultaneous events: a req_valid arriving in the same cycle as the S_WAIT_DONE → S_IDLE transition is arbitrated in the following S_IDLE cycle. No same-cycle bypass.
- Reset mid-operation: everything returns to reset values. uart_tx is reset by the same i_rst_n, so no partial frame handling is needed.
- Width rules: rr_ptr and the winner index are clog2(NUM_REQ) bits. The timeout counter is clog2(BUSY_TIMEOUT)+1 bits.

Decomposition:
- Shared include file uart_defs.vh:
  - state codes for S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE
  - UART_FRAME_BITS = 11 (start, 8 data, parity, stop)
  - default NUM_REQ
- One natural sub-module: rr_arbiter.
  - Combinational rotate / priority-encode / un-rotate.
  - Inputs: request vector, pointer. Outputs: one-hot winner, winner index, any-valid.
- The FSM, lock and pointer registers stay in uart_tx_sched.

Test Plan:
1. Bench setup: DUT connected to a uart_tx instance with clk_frequency=27 and baud_rate=115200 (234 cycles per bit).
2. Single byte: req_valid=0001, req_data[7:0]=0xA5, req_last=1 → next cycle tx_valid=1 for one cycle, tx_data=0xA5, req_ready=0001 pulse, grant=0001. Serial line shows 0, 10100101 LSB-first, parity 0, 1. busy falls 1 cycle after ready_tx rises; rr_ptr=1.
3. Fairness: all four requesting single bytes 0x10..0x13 with rr_ptr=0 → issue order 0,1,2,3. Then req0 and req3 both pending with rr_ptr=0 → req0 first. Re-run with rr_ptr=2 → req3 first.
4. Packet lock: req1 sends 0x31,0x32,0x33 with last on 0x33 while req2 holds valid with 0x44 → order 0x31,0x32,0x33,0x44. grant stays 0010 across all three frames.
5. Timeout: tx_ready tied to 1 (stub), single request → err_timeout pulses exactly once, BUSY_TIMEOUT cycles after S_ISSUE. grant=0, state S_IDLE, no further accept without a new req_valid.
6. Reset mid-frame and withdrawn request:
   - Assert i_rst_n=0 during S_WAIT_DONE of a locked packet → all outputs at reset values immediately. After release, a req2 request is granted and the lock is gone.
   - A req_valid pulse deasserted before reaching S_IDLE → no req_ready and no tx_valid.
